// File: rtl/wm8731_config.sv
// Purpose : I2C master that writes the fixed 11-word WM8731 register set on a start pulse.
// Latency : busy the cycle after start; every SCL/SDA change lands on a quarter-bit tick.
// Backpressure: none; a start while busy is dropped, and a NACKed word is retried then flagged.
//
// Ports
//   clk, reset_n        system clock, synchronous active-low reset
//   start               single-cycle request, honoured only when idle/done/error
//   i2c_sclk            push-pull SCL
//   i2c_sdat_oe         1 = pull SDA low, 0 = release (open-drain emulation)
//   i2c_sdat_in         sampled SDA pin level
//   busy, done, error   status levels; done/error hold until the next start
module wm8731_config #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int I2C_HZ    = 100_000,
    parameter int MAX_TRIES = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic i2c_sclk,
    output logic i2c_sdat_oe,
    input  logic i2c_sdat_in,
    output logic busy,
    output logic done,
    output logic error
);

    // Clocks per quarter SCL period.
    localparam int DIV   = CLK_HZ / (4 * I2C_HZ);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [TRY_W-1:0] TRY_LIMIT  = TRY_W'(MAX_TRIES);
    localparam logic [3:0]       LAST_INDEX = 4'd10;
    localparam logic [7:0]       DEV_ADDR_W = 8'h34;   // 7-bit 0x1A, write

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_ACK,
        S_STOP,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [1:0]        phase;
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_cnt;
    logic [3:0]        index;
    logic [TRY_W-1:0]  tries;
    logic              ack_seen;   // slave pulled SDA low during the current ACK slot
    logic              word_ok;    // last finished word was fully acknowledged
    logic              accept;

    logic [15:0]       cur_word;
    logic [7:0]        tx_byte;
    logic              scl_nxt;
    logic              sda_oe_nxt;

    // Register set: {reg[6:0], data[8:0]}; reset first, active last.
    function automatic logic [15:0] rom_word(input logic [3:0] idx);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'h1E00;   // reset
            4'd1:    w = 16'h0017;   // left line in
            4'd2:    w = 16'h0217;   // right line in
            4'd3:    w = 16'h0479;   // left headphone out
            4'd4:    w = 16'h0679;   // right headphone out
            4'd5:    w = 16'h0812;   // analogue path
            4'd6:    w = 16'h0A00;   // digital path
            4'd7:    w = 16'h0C00;   // power down control
            4'd8:    w = 16'h0E02;   // digital audio interface format
            4'd9:    w = 16'h1000;   // sampling control
            4'd10:   w = 16'h1201;   // active
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    assign accept = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign tick   = busy && (div_cnt == DIV_LAST);

    assign cur_word = rom_word(index);

    always_comb begin
        tx_byte = DEV_ADDR_W;
        case (byte_cnt)
            2'd1:    tx_byte = cur_word[15:8];
            2'd2:    tx_byte = cur_word[7:0];
            default: tx_byte = DEV_ADDR_W;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; every bus-phase transition waits for the tick
    // that closes the last quarter of the current phase.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_nxt = S_START;
            end
            S_START: begin
                if (tick && (phase == 2'd3)) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (tick && (phase == 2'd3) && (bit_cnt == 3'd7)) state_nxt = S_ACK;
            end
            S_ACK: begin
                if (tick && (phase == 2'd3)) begin
                    // A NACK on any byte abandons the rest of the word.
                    if (ack_seen && (byte_cnt != 2'd2)) state_nxt = S_SHIFT;
                    else                                state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // STOP is two quarters; the SDA release opens the gap.
                if (tick && (phase == 2'd1)) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (tick && (phase == 2'd3)) begin
                    if (word_ok) begin
                        state_nxt = (index == LAST_INDEX) ? S_DONE : S_START;
                    end else begin
                        state_nxt = (tries >= TRY_LIMIT) ? S_ERROR : S_START;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and ACK bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            phase    <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            index    <= 4'd0;
            tries    <= '0;
            ack_seen <= 1'b0;
            word_ok  <= 1'b0;
        end else if (accept) begin
            // Restart the divider so the first quarter is a full DIV long.
            div_cnt  <= '0;
            phase    <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            index    <= 4'd0;
            tries    <= '0;
            ack_seen <= 1'b0;
            word_ok  <= 1'b0;
        end else if (busy) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                phase <= ((state == S_STOP) && (phase == 2'd1)) ? 2'd0 : phase + 2'd1;
                case (state)
                    S_START: begin
                        bit_cnt  <= 3'd0;
                        byte_cnt <= 2'd0;
                        ack_seen <= 1'b0;
                    end
                    S_SHIFT: begin
                        // Wraps 7 -> 0, ready for the next byte.
                        if (phase == 2'd3) bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_ACK: begin
                        // Sample at the end of q2, after SCL has been high two quarters.
                        if (phase == 2'd2) ack_seen <= ~i2c_sdat_in;
                        if (phase == 2'd3) begin
                            if (!ack_seen) begin
                                tries   <= tries + TRY_W'(1);
                                word_ok <= 1'b0;
                            end else if (byte_cnt == 2'd2) begin
                                tries   <= '0;
                                word_ok <= 1'b1;
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                        end
                    end
                    S_GAP: begin
                        if ((phase == 2'd3) && word_ok && (index != LAST_INDEX)) begin
                            index <= index + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode. Within every phase SCL and SDA never change on the
    // same quarter boundary except where the other line is held stable,
    // so SDA moves under SCL-high only for START and STOP.
    // ------------------------------------------------------------------
    always_comb begin
        scl_nxt    = 1'b1;
        sda_oe_nxt = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            S_START: begin
                busy       = 1'b1;
                scl_nxt    = (phase != 2'd3);
                sda_oe_nxt = (phase != 2'd0);
            end
            S_SHIFT: begin
                busy       = 1'b1;
                scl_nxt    = (phase == 2'd1) || (phase == 2'd2);
                sda_oe_nxt = ~tx_byte[3'd7 - bit_cnt];
            end
            S_ACK: begin
                busy       = 1'b1;
                scl_nxt    = (phase == 2'd1) || (phase == 2'd2);
                sda_oe_nxt = 1'b0;
            end
            S_STOP: begin
                busy       = 1'b1;
                scl_nxt    = (phase == 2'd1);
                sda_oe_nxt = 1'b1;
            end
            S_GAP: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: ;
        endcase
    end

    // Pin registers keep the bus lines glitch-free; both lines share the
    // same one-cycle lag so their relative ordering is preserved.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            i2c_sclk    <= 1'b1;
            i2c_sdat_oe <= 1'b0;
        end else begin
            i2c_sclk    <= scl_nxt;
            i2c_sdat_oe <= sda_oe_nxt;
        end
    end

endmodule

// File: tb/tb_wm8731_config.sv
// Purpose : directed bench for wm8731_config with an I2C slave/decoder and protocol monitor.
// Latency : n/a (testbench).
// Backpressure: slave ACKs by default; NACK patterns selected per run.
module tb_wm8731_config;

    // Small divider keeps runs short: DIV = 4, SCL period 16 clocks.
    localparam int CLK_HZ = 4_000_000;
    localparam int I2C_HZ = 250_000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic sclk, sdat_oe, sdat_in, busy, done, error;
    logic slave_pull = 1'b0;

    assign sdat_in = ~(sdat_oe | slave_pull);

    wm8731_config #(.CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ), .MAX_TRIES(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .i2c_sclk    (sclk),
        .i2c_sdat_oe (sdat_oe),
        .i2c_sdat_in (sdat_in),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    // Default-parameter instance, used only to measure the real SCL period.
    logic start_def = 1'b0;
    logic sclk_def, oe_def, sdat_in_def, busy_def, done_def, err_def;
    assign sdat_in_def = ~oe_def;

    wm8731_config dut_def (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start_def),
        .i2c_sclk    (sclk_def),
        .i2c_sdat_oe (oe_def),
        .i2c_sdat_in (sdat_in_def),
        .busy        (busy_def),
        .done        (done_def),
        .error       (err_def)
    );

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ------------------------------------------------------------------
    // Slave model / bus monitor, sampled on the falling clock edge
    // ------------------------------------------------------------------
    int         rises     = 0;
    int         pulses    = 0;
    int         stops     = 0;
    int         proto_err = 0;
    int         rx_n      = 0;
    int         addr_idx  = 0;
    int         byte_pos  = 0;
    int         bitc      = 0;
    int         nack_mode = 0;
    int         rise_cyc [2];
    logic [7:0] rx [64];
    logic [7:0] byte_sh   = 8'h00;
    logic       prev_scl  = 1'b1;
    logic       prev_sda  = 1'b1;
    logic       in_xfer   = 1'b0;
    logic       pulse_open = 1'b0;
    logic       bit_smp   = 1'b0;
    logic       mscl, msda, ack;

    always @(negedge clk) begin
        mscl = sclk;
        msda = sdat_in;
        if (!reset_n) begin
            in_xfer    = 1'b0;
            pulse_open = 1'b0;
            bitc       = 0;
            slave_pull = 1'b0;
        end else begin
            if (mscl && !prev_scl) begin
                if (rises < 2) rise_cyc[rises] = cyc;
                rises++;
                pulse_open = 1'b1;
                bit_smp    = msda;
            end else if (mscl && prev_scl && (msda != prev_sda)) begin
                pulse_open = 1'b0;
                if (!msda) begin
                    if (in_xfer) proto_err++;
                    in_xfer  = 1'b1;
                    bitc     = 0;
                    byte_pos = 0;
                end else begin
                    if (!in_xfer || bitc != 0) proto_err++;
                    in_xfer = 1'b0;
                    stops++;
                end
            end else if (!mscl && prev_scl && pulse_open && in_xfer) begin
                pulse_open = 1'b0;
                pulses++;
                if (bitc < 8) begin
                    byte_sh = {byte_sh[6:0], bit_smp};
                    bitc++;
                    if (bitc == 8) begin
                        if (rx_n < 64) rx[rx_n] = byte_sh;
                        rx_n++;
                        ack = 1'b1;
                        if (byte_pos == 0) begin
                            if (nack_mode == 2 || (nack_mode == 1 && addr_idx == 3)) ack = 1'b0;
                            addr_idx++;
                        end
                        slave_pull = ack;
                    end
                end else begin
                    slave_pull = 1'b0;
                    bitc       = 0;
                    byte_pos++;
                end
            end
            if (mscl && in_xfer && bitc == 8 && sdat_oe) proto_err++;
        end
        prev_scl = mscl;
        prev_sda = msda;
    end

    task automatic clear_run(input int mode);
        rises     = 0;
        pulses    = 0;
        stops     = 0;
        proto_err = 0;
        rx_n      = 0;
        addr_idx  = 0;
        rise_cyc[0] = 0;
        rise_cyc[1] = 0;
        nack_mode = mode;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int limit);
        int n;
        n = 0;
        while (!(done || error) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {31'b0, (done || error)}, 32'd1);
    endtask

    task automatic wait_addr(input string tag, input int target, input int limit);
        int n;
        n = 0;
        while (addr_idx < target && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, addr_idx, target);
    endtask

    logic [15:0] exp_words [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                                    16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201};
    logic [7:0]  exp_b [33];

    initial begin
        int idle_bad;
        int nr;
        int t_def [2];
        logic pd;
        int r0;
        logic [7:0] eb;

        for (int w = 0; w < 11; w++) begin
            exp_b[3*w]     = 8'h34;
            exp_b[3*w + 1] = exp_words[w][15:8];
            exp_b[3*w + 2] = exp_words[w][7:0];
        end

        // Reset for two cycles
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sclk", {31'b0, sclk}, 32'd1);
        chk("rst_oe",   {31'b0, sdat_oe}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err",  {31'b0, error}, 32'd0);
        reset_n = 1'b1;

        // 1000 idle cycles: no auto-start, bus released
        idle_bad = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (sclk !== 1'b1 || sdat_oe !== 1'b0 || busy !== 1'b0 ||
                done !== 1'b0 || error !== 1'b0) idle_bad++;
        end
        chk("idle_quiet", idle_bad, 0);

        // SCL period at default parameters: 4 * 125 = 500 clocks
        start_def = 1'b1;
        @(posedge clk); #1;
        start_def = 1'b0;
        nr = 0;
        t_def[0] = 0;
        t_def[1] = 0;
        pd = sclk_def;
        for (int i = 0; i < 3000 && nr < 2; i++) begin
            @(posedge clk); #1;
            if (sclk_def && !pd) begin
                t_def[nr] = cyc;
                nr++;
            end
            pd = sclk_def;
        end
        chk("def_rises_seen", nr, 2);
        chk("def_scl_period", t_def[1] - t_def[0], 500);

        // Run 1: slave always ACKs
        clear_run(0);
        pulse_start();
        chk("r1_busy_after_start", {31'b0, busy}, 32'd1);
        chk("r1_done_after_start", {31'b0, done}, 32'd0);
        wait_end("r1_finished", 8000);
        chk("r1_done",   {31'b0, done}, 32'd1);
        chk("r1_error",  {31'b0, error}, 32'd0);
        chk("r1_busy",   {31'b0, busy}, 32'd0);
        chk("r1_sclk",   {31'b0, sclk}, 32'd1);
        chk("r1_oe",     {31'b0, sdat_oe}, 32'd0);
        chk("r1_nbytes", rx_n, 33);
        for (int i = 0; i < 33; i++) chk($sformatf("r1_byte%0d", i), {24'b0, rx[i]}, {24'b0, exp_b[i]});
        chk("r1_scl_pulses", pulses, 297);
        chk("r1_stops",      stops, 11);
        chk("r1_period",     rise_cyc[1] - rise_cyc[0], 16);
        chk("r1_protocol",   proto_err, 0);

        // Run 2: single NACK on word 3 address byte
        clear_run(1);
        pulse_start();
        chk("r2_busy_after_start", {31'b0, busy}, 32'd1);
        chk("r2_done_cleared",     {31'b0, done}, 32'd0);
        wait_end("r2_finished", 8000);
        chk("r2_done",   {31'b0, done}, 32'd1);
        chk("r2_error",  {31'b0, error}, 32'd0);
        chk("r2_nbytes", rx_n, 34);
        for (int i = 0; i < 34; i++) begin
            if (i < 9)       eb = exp_b[i];
            else if (i == 9) eb = 8'h34;
            else             eb = exp_b[i - 1];
            chk($sformatf("r2_byte%0d", i), {24'b0, rx[i]}, {24'b0, eb});
        end
        chk("r2_addr_count", addr_idx, 12);
        chk("r2_stops",      stops, 12);
        chk("r2_scl_pulses", pulses, 306);
        chk("r2_protocol",   proto_err, 0);

        // Run 3: permanent NACK on word 0
        clear_run(2);
        pulse_start();
        chk("r3_busy_after_start", {31'b0, busy}, 32'd1);
        wait_end("r3_finished", 8000);
        chk("r3_error",  {31'b0, error}, 32'd1);
        chk("r3_done",   {31'b0, done}, 32'd0);
        chk("r3_busy",   {31'b0, busy}, 32'd0);
        chk("r3_nbytes", rx_n, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("r3_addr%0d", i), {24'b0, rx[i]}, 32'h34);
        chk("r3_stops",      stops, 3);
        chk("r3_scl_pulses", pulses, 27);
        chk("r3_protocol",   proto_err, 0);
        r0 = rises;
        repeat (200) @(posedge clk);
        #1;
        chk("r3_no_scl_after_error", rises - r0, 0);
        chk("r3_sclk_idle", {31'b0, sclk}, 32'd1);
        chk("r3_oe_idle",   {31'b0, sdat_oe}, 32'd0);

        // Run 4: extra start during word 2, reset during word 5
        clear_run(0);
        pulse_start();
        chk("r4_busy_after_start", {31'b0, busy}, 32'd1);
        chk("r4_error_cleared",    {31'b0, error}, 32'd0);
        wait_addr("r4_reached_word2", 3, 3000);
        pulse_start();
        chk("r4_busy_after_extra_start", {31'b0, busy}, 32'd1);
        wait_addr("r4_reached_word5", 6, 3000);
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("r4_rst_sclk", {31'b0, sclk}, 32'd1);
        chk("r4_rst_oe",   {31'b0, sdat_oe}, 32'd0);
        chk("r4_rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("r4_nbytes_before_reset", rx_n, 16);
        for (int i = 0; i < 16; i++) chk($sformatf("r4_byte%0d", i), {24'b0, rx[i]}, {24'b0, exp_b[i]});
        chk("r4_protocol", proto_err, 0);

        clear_run(0);
        repeat (10) @(posedge clk);
        #1;
        pulse_start();
        wait_end("r4b_finished", 8000);
        chk("r4b_done",   {31'b0, done}, 32'd1);
        chk("r4b_nbytes", rx_n, 33);
        for (int i = 0; i < 33; i++) chk($sformatf("r4b_byte%0d", i), {24'b0, rx[i]}, {24'b0, exp_b[i]});
        chk("r4b_protocol", proto_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wm8731_config.md
WM8731_CONFIG -- requirements
Module: wm8731_config

Interface
REQ-001 Parameter CLK_HZ, 50_000_000, system clock frequency.
REQ-002 Parameter I2C_HZ, 100_000, SCL frequency; DIV = CLK_HZ/(4*I2C_HZ) clocks per quarter-bit (125 at defaults).
REQ-003 Parameter MAX_TRIES, 3, total attempts per register word before error.
REQ-004 clk  in  1  system clock (CLOCK_50); all logic on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  single-cycle request to run the full configuration sequence.
REQ-007 i2c_sclk  out  1  SCL, push-pull, drives FPGA_I2C_SCLK.
REQ-008 i2c_sdat_oe  out  1  1 = pull SDA low, 0 = release (top ties FPGA_I2C_SDAT to 0 or Z).
REQ-009 i2c_sdat_in  in  1  sampled SDA pin level.
REQ-010 busy  out  1  sequence in progress.
REQ-011 done  out  1  level; all words acknowledged; held until the next start.
REQ-012 error  out  1  level; a word failed MAX_TRIES times; held until the next start.

Function
REQ-013 Fixed ROM of 11 16-bit words {reg[6:0],data[8:0]}, sent in order: 1E00, 0017, 0217, 0479, 0679, 0812, 0A00, 0C00, 0E02, 1000, 1201.
REQ-014 Each word is one I2C write: START, 0x34, ACK, word[15:8], ACK, word[7:0], ACK, STOP; MSB first.
REQ-015 Quarter-bit tick every DIV clocks; every SCL/SDA change occurs only on a tick.
REQ-016 Data bit: q0 SCL low and SDA set; q1 SCL high; q2 SCL high, SDA sampled; q3 SCL low. SDA never changes while SCL is high except for START/STOP.
REQ-017 START: SCL high, SDA released 1 quarter; SDA low 2 quarters; then SCL low.
REQ-018 STOP: SCL low, SDA low; SCL high 1 quarter; then SDA released.
REQ-019 ACK slot: SDA released in q0; ACK when i2c_sdat_in==0 at q2; NACK otherwise.
REQ-020 States: IDLE, START, SHIFT, ACK, STOP, GAP, DONE, ERROR; counters: tick divider, phase[1:0], bit[2:0], byte[1:0], index[3:0], tries.
REQ-021 Transitions: IDLE/DONE/ERROR --start--> START; START->SHIFT; SHIFT after 8 bits->ACK; ACK+ACK, byte<2 -> SHIFT; ACK+ACK, byte==2 -> STOP (word ok); any NACK -> STOP (word failed).
REQ-022 STOP->GAP: bus idle (SCL high, SDA released) 4 quarters; then next word, retry of the same word, DONE after index 10 ok, or ERROR.
REQ-023 NACK: abort the rest of the word, STOP, increment tries; tries<MAX_TRIES retries the same index, else ERROR; tries clears on every acknowledged word.
REQ-024 start accepted on the clock edge it is high in IDLE/DONE/ERROR: next cycle busy=1, done=0, error=0, index=0, tries=0.
REQ-025 start while busy is ignored and not queued.
REQ-026 DONE/ERROR: busy=0, SCL high, SDA released, no bus activity.

Reset
REQ-027 reset_n low at a clock edge: next cycle state=IDLE, i2c_sclk=1, i2c_sdat_oe=0, busy=0, done=0, error=0, all counters 0; no auto-start.
REQ-028 Reset mid-transaction abandons the word without a STOP; the next start begins at index 0.

Verification
REQ-029 Reset for 2 cycles, then 1000 idle cycles -> sclk=1, sdat_oe=0, busy=0, done=0, error=0 throughout.
REQ-030 Slave model always ACKs, start pulse -> bytes decoded 34 1E 00 ... 34 12 01 (33 bytes), SCL period 500 clks, 297 SCL rising edges; then done=1, busy=0.
REQ-031 Single NACK on word 3 address byte -> word 3 STOP, retried once, all 11 words acked, done=1, error=0.
REQ-032 Permanent NACK on word 0 -> exactly 3 attempts of 0x34, then error=1, done=0, busy=0, no further SCL edges.
REQ-033 Second start during word 2 -> ignored (one sequence only); reset_n low during word 5 -> released bus next cycle, new start resends from 1E00.
REQ-034 Protocol checker on every run -> SDA never changes while SCL high outside START/STOP, ACK slot always released.
